maze_builder: RTL and testbench
===============================

MAZE_BUILDER -- requirements
Module: maze_builder

Interface
REQ-001 Parameter: COLS, default 40, maze width in tiles, each tile 16x16 pixels of the 640x480 screen.
REQ-002 Parameter: ROWS, default 30, maze height in tiles.
REQ-003 Parameter: AW, default 11, tile address width; AW SHALL satisfy 2^AW >= COLS*ROWS.
REQ-004 board_clk  input  1  clock; all state changes on its rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to (re)build the maze.
REQ-007 rect_valid  input  1  a wall rectangle is offered.
REQ-008 rect_x0, rect_x1  input  6 each  inclusive tile column bounds.
REQ-009 rect_y0, rect_y1  input  5 each  inclusive tile row bounds.
REQ-010 rect_last  input  1  the offered rectangle is the final one.
REQ-011 rect_ready  output  1  builder accepts a rectangle this cycle.
REQ-012 wr_en  output  1  tile memory write strobe.
REQ-013 wr_addr  output  AW  tile address, y*COLS+x.
REQ-014 wr_data  output  2  {food, wall} tile value.
REQ-015 busy  output  1  high in CLEAR, WAIT_RECT and FILL.
REQ-016 done  output  1  maze complete, level, held until next start or Reset.
REQ-017 wall_writes  output  11  count of wall tile writes since the last start, saturating at 2047.
REQ-018 err_count  output  4  count of rejected rectangles since the last start, saturating at 15.

Function
REQ-019 The block SHALL implement states IDLE, CLEAR, WAIT_RECT, FILL and DONE.
REQ-020 wr_en, wr_addr, wr_data SHALL be registered outputs.
REQ-021 IDLE or DONE with start=1 SHALL go to CLEAR on the next edge and clear wall_writes, err_count and done.
REQ-022 start in CLEAR, WAIT_RECT or FILL SHALL be ignored.
REQ-023 CLEAR SHALL write wr_data=2'b10 (food=1, wall=0) to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, with no gaps.
REQ-024 The first clear write SHALL appear the cycle after start is sampled; after the last one (address 1199 at defaults) the state SHALL be WAIT_RECT.
REQ-025 rect_ready SHALL equal 1 only in WAIT_RECT; a handshake is rect_valid and rect_ready both high on an edge.
REQ-026 A rectangle with x0>x1, y0>y1, x1>=COLS or y1>=ROWS SHALL be rejected: err_count increments, there are no writes, and the state stays WAIT_RECT, or goes to DONE if rect_last=1.
REQ-027 An accepted valid rectangle SHALL move the state to FILL, with its bounds and rect_last latched.
REQ-028 FILL SHALL write wr_data=2'b01 to each tile in row-major order (x fastest), one per cycle, starting the cycle after the handshake.
REQ-029 FILL SHALL take exactly (x1-x0+1)*(y1-y0+1) cycles; a 1x1 rectangle takes 1 cycle.
REQ-030 Each FILL write SHALL increment wall_writes.
REQ-031 Overlapping rectangles SHALL rewrite tiles and count again.
REQ-032 After the final FILL write the state SHALL be WAIT_RECT, or DONE if the latched rect_last=1.
REQ-033 wr_en SHALL be 0 in IDLE, WAIT_RECT and DONE.
REQ-034 wr_addr and wr_data SHALL hold their last value when wr_en=0.

Reset
REQ-035 Reset=1 SHALL immediately force state IDLE and clear wr_en, wr_addr, wr_data, busy, done, wall_writes and err_count to 0, even mid-CLEAR or mid-FILL.
REQ-036 rect_ready SHALL be 0 while Reset is asserted.
REQ-037 After Reset deasserts, no write SHALL occur until start is sampled.

Verification
REQ-038 Reset, then a start pulse -> 1200 consecutive writes, addresses 0..1199, data 2'b10; rect_ready rises on the next cycle; busy=1 throughout.
REQ-039 In WAIT_RECT, offer rect (2,3)-(4,4) with rect_last=1 -> 6 writes, addresses 122,123,124,162,163,164, data 2'b01; done=1 on the next cycle; wall_writes=6.
REQ-040 Offer rect x0=5, x1=3 and then rect (39,29)-(39,29) with rect_last=1 -> err_count=1; a single write to address 1199; done=1.
REQ-041 Pulse start during CLEAR at address 500 -> no restart and the sequence reaches 1199 uninterrupted; Reset asserted mid-FILL -> wr_en=0 within the same cycle, state IDLE, all counters 0.
REQ-042 Offer 20 invalid rectangles -> err_count saturates at 15; a later start clears it to 0.

Source files
------------

// File: rtl/maze_builder.sv
// Maze tile builder: clears the tile memory to food, then paints wall rectangles
// supplied over a valid/ready handshake, one registered tile write per cycle.
module maze_builder #(
   parameter int COLS = 40,
   parameter int ROWS = 30,
   parameter int AW   = 11
) (
   input  logic          board_clk,
   input  logic          Reset,
   input  logic          start,
   input  logic          rect_valid,
   input  logic [5:0]    rect_x0,
   input  logic [5:0]    rect_x1,
   input  logic [4:0]    rect_y0,
   input  logic [4:0]    rect_y1,
   input  logic          rect_last,
   output logic          rect_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [1:0]    wr_data,
   output logic          busy,
   output logic          done,
   output logic [10:0]   wall_writes,
   output logic [3:0]    err_count
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CLEAR     = 3'd1;
   localparam logic [2:0] WAIT_RECT = 3'd2;
   localparam logic [2:0] FILL      = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;

   localparam logic [AW-1:0] COLS_A = AW'(COLS);
   localparam logic [AW-1:0] LAST_A = AW'(COLS * ROWS - 1);
   localparam logic [6:0]    COLS_W = 7'(COLS);
   localparam logic [5:0]    ROWS_W = 6'(ROWS);

   logic [2:0]    state;
   logic [5:0]    cx, lx0, lx1;
   logic [4:0]    cy, ly1;
   logic          llast;
   logic [AW-1:0] row_base;

   logic          rect_bad;
   logic          fill_last;
   logic [AW-1:0] rect_base;
   logic [10:0]   wall_inc;
   logic [3:0]    err_inc;

   assign rect_ready = (state == WAIT_RECT);
   assign busy       = (state == CLEAR) || (state == WAIT_RECT) || (state == FILL);

   assign rect_bad  = (rect_x0 > rect_x1) || (rect_y0 > rect_y1) ||
                      ({1'b0, rect_x1} >= COLS_W) || ({1'b0, rect_y1} >= ROWS_W);
   assign rect_base = AW'(rect_y0) * COLS_A;
   assign fill_last = (cx == lx1) && (cy == ly1);
   assign wall_inc  = (wall_writes == 11'h7FF) ? wall_writes : wall_writes + 11'd1;
   assign err_inc   = (err_count == 4'hF) ? err_count : err_count + 4'd1;

   // NOTE: sequential state uses <= so every register sees pre-edge values.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= 2'b00;
         done        <= 1'b0;
         wall_writes <= '0;
         err_count   <= '0;
         cx          <= '0;
         cy          <= '0;
         lx0         <= '0;
         lx1         <= '0;
         ly1         <= '0;
         llast       <= 1'b0;
         row_base    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= CLEAR;
                  wr_en       <= 1'b1;
                  wr_addr     <= '0;
                  wr_data     <= 2'b10;
                  done        <= 1'b0;
                  wall_writes <= '0;
                  err_count   <= '0;
               end
            end
            CLEAR: begin
               if (wr_addr == LAST_A) begin
                  wr_en <= 1'b0;
                  state <= WAIT_RECT;
               end else begin
                  wr_addr <= wr_addr + 1'b1;
               end
            end
            WAIT_RECT: begin
               if (rect_valid) begin
                  if (rect_bad) begin
                     err_count <= err_inc;
                     if (rect_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     state       <= FILL;
                     wr_en       <= 1'b1;
                     wr_addr     <= rect_base + AW'(rect_x0);
                     wr_data     <= 2'b01;
                     wall_writes <= wall_inc;
                     lx0         <= rect_x0;
                     lx1         <= rect_x1;
                     ly1         <= rect_y1;
                     llast       <= rect_last;
                     cx          <= rect_x0;
                     cy          <= rect_y0;
                     row_base    <= rect_base;
                  end
               end
            end
            FILL: begin
               if (fill_last) begin
                  wr_en <= 1'b0;
                  state <= llast ? DONE : WAIT_RECT;
                  done  <= llast;
               end else if (cx == lx1) begin
                  // Wrap to the left edge of the next row.
                  cx          <= lx0;
                  cy          <= cy + 5'd1;
                  row_base    <= row_base + COLS_A;
                  wr_addr     <= row_base + COLS_A + AW'(lx0);
                  wall_writes <= wall_inc;
               end else begin
                  cx          <= cx + 6'd1;
                  wr_addr     <= wr_addr + 1'b1;
                  wall_writes <= wall_inc;
               end
            end
            default: begin
               state <= IDLE;
               wr_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maze_builder.sv
// Bench for maze_builder: a queue of expected tile writes built from the maze
// rules, checked against every DUT write, plus literal spot checks.
module tb_maze_builder;

   localparam int COLS = 40;
   localparam int ROWS = 30;
   localparam int AW   = 11;

   logic          board_clk = 1'b0;
   logic          Reset = 1'b1;
   logic          start = 1'b0;
   logic          rect_valid = 1'b0;
   logic [5:0]    rect_x0 = '0, rect_x1 = '0;
   logic [4:0]    rect_y0 = '0, rect_y1 = '0;
   logic          rect_last = 1'b0;
   logic          rect_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [1:0]    wr_data;
   logic          busy;
   logic          done;
   logic [10:0]   wall_writes;
   logic [3:0]    err_count;

   maze_builder #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
      .board_clk  (board_clk),
      .Reset      (Reset),
      .start      (start),
      .rect_valid (rect_valid),
      .rect_x0    (rect_x0),
      .rect_x1    (rect_x1),
      .rect_y0    (rect_y0),
      .rect_y1    (rect_y1),
      .rect_last  (rect_last),
      .rect_ready (rect_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .wall_writes(wall_writes),
      .err_count  (err_count)
   );

   always #5 board_clk = ~board_clk;

   int         n_cmp = 0;
   int         n_err = 0;
   int         exp_addr[$];
   logic [1:0] exp_data[$];
   int         model_walls = 0;
   int         model_errs = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every DUT write must match the head of the expected queue.
   always @(negedge board_clk) begin
      int         a;
      logic [1:0] d;
      if (!Reset && wr_en) begin
         if (exp_addr.size() == 0) begin
            check("spurious_wr_en", 32'(wr_en), 32'd0);
         end else begin
            a = exp_addr.pop_front();
            d = exp_data.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(a));
            check("wr_data", 32'(wr_data), 32'(d));
            if (d == 2'b01) begin
               if (model_walls < 2047) model_walls++;
               check("wall_writes", 32'(wall_writes), 32'(model_walls));
            end
         end
      end
   end

   function automatic bit rect_ok(input int x0, input int x1, input int y0, input int y1);
      return (x0 <= x1) && (y0 <= y1) && (x1 < COLS) && (y1 < ROWS);
   endfunction

   task automatic push_clear();
      for (int i = 0; i < COLS * ROWS; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back(2'b10);
      end
   endtask

   task automatic push_rect(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) begin
            exp_addr.push_back(y * COLS + x);
            exp_data.push_back(2'b01);
         end
   endtask

   task automatic pulse_start();
      start       = 1'b1;
      model_walls = 0;
      model_errs  = 0;
      @(negedge board_clk);
      start = 1'b0;
      check("start_clears_done", 32'(done), 32'd0);
      check("start_clears_err", 32'(err_count), 32'd0);
      check("start_clears_walls", 32'(wall_writes), 32'd0);
      check("start_busy", 32'(busy), 32'd1);
   endtask

   // Measures a run of consecutive writes; optionally pokes start mid-clear.
   task automatic burst(input int n, input string name, input bit poke);
      int w;
      int run;
      w   = 0;
      run = 0;
      while (!wr_en && w < 20) begin
         @(negedge board_clk);
         w++;
      end
      while (wr_en && run < n + 10) begin
         check({name, "_busy"}, 32'(busy), 32'd1);
         start = poke && (wr_addr == AW'(500));
         run++;
         @(negedge board_clk);
      end
      start = 1'b0;
      check({name, "_len"}, 32'(run), 32'(n));
   endtask

   task automatic offer(input int x0, input int x1, input int y0, input int y1,
                        input bit last, input bit model);
      int w;
      w = 0;
      while (!rect_ready && w < 50) begin
         @(negedge board_clk);
         w++;
      end
      check("rect_ready_wait", 32'(rect_ready), 32'd1);
      rect_x0    = 6'(x0);
      rect_x1    = 6'(x1);
      rect_y0    = 5'(y0);
      rect_y1    = 5'(y1);
      rect_last  = last;
      rect_valid = 1'b1;
      if (!rect_ok(x0, x1, y0, y1)) begin
         if (model_errs < 15) model_errs++;
      end else if (model) begin
         push_rect(x0, x1, y0, y1);
      end
      @(negedge board_clk);
      rect_valid = 1'b0;
      rect_last  = 1'b0;
      if (!rect_ok(x0, x1, y0, y1)) begin
         check("reject_err_count", 32'(err_count), 32'(model_errs));
         check("reject_no_write", 32'(wr_en), 32'd0);
      end
   endtask

   initial begin
      repeat (3) @(negedge board_clk);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_walls", 32'(wall_writes), 32'd0);
      check("rst_errs", 32'(err_count), 32'd0);
      check("rst_rect_ready", 32'(rect_ready), 32'd0);
      Reset = 1'b0;
      repeat (10) @(negedge board_clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rect_ready", 32'(rect_ready), 32'd0);

      // Clear then a single 3x2 wall with literal addresses.
      push_clear();
      pulse_start();
      burst(COLS * ROWS, "clear1", 1'b0);
      check("clear1_rect_ready", 32'(rect_ready), 32'd1);
      foreach (exp_addr[i]) check("clear1_drained", 32'(i), 32'd0);
      for (int i = 0; i < 3; i++) begin
         exp_addr.push_back(122 + i);
         exp_data.push_back(2'b01);
      end
      for (int i = 0; i < 3; i++) begin
         exp_addr.push_back(162 + i);
         exp_data.push_back(2'b01);
      end
      offer(2, 4, 3, 4, 1'b1, 1'b0);
      burst(6, "rect1", 1'b0);
      check("rect1_done", 32'(done), 32'd1);
      check("rect1_walls", 32'(wall_writes), 32'd6);
      check("rect1_busy", 32'(busy), 32'd0);
      check("rect1_ready_low", 32'(rect_ready), 32'd0);

      // Start ignored mid-clear, then a reject followed by a corner tile.
      push_clear();
      pulse_start();
      burst(COLS * ROWS, "clear2", 1'b1);
      offer(5, 3, 0, 0, 1'b0, 1'b1);
      check("bad_x_err", 32'(err_count), 32'd1);
      check("bad_x_still_waiting", 32'(rect_ready), 32'd1);
      exp_addr.push_back(1199);
      exp_data.push_back(2'b01);
      offer(39, 39, 29, 29, 1'b1, 1'b0);
      burst(1, "corner", 1'b0);
      check("corner_done", 32'(done), 32'd1);
      check("corner_walls", 32'(wall_writes), 32'd1);
      check("corner_err", 32'(err_count), 32'd1);

      // Overlapping walls count twice; then Reset mid-fill.
      push_clear();
      pulse_start();
      burst(COLS * ROWS, "clear3", 1'b0);
      offer(0, 1, 0, 1, 1'b0, 1'b1);
      burst(4, "sq2x2", 1'b0);
      offer(1, 2, 1, 1, 1'b0, 1'b1);
      burst(2, "overlap", 1'b0);
      check("overlap_walls", 32'(wall_writes), 32'd6);
      offer(0, 39, 0, 29, 1'b1, 1'b1);
      repeat (10) @(negedge board_clk);
      #1;
      exp_addr.delete();
      exp_data.delete();
      model_walls = 0;
      Reset = 1'b1;
      #1;
      check("midfill_rst_wr_en", 32'(wr_en), 32'd0);
      check("midfill_rst_busy", 32'(busy), 32'd0);
      check("midfill_rst_ready", 32'(rect_ready), 32'd0);
      check("midfill_rst_walls", 32'(wall_writes), 32'd0);
      check("midfill_rst_err", 32'(err_count), 32'd0);
      check("midfill_rst_done", 32'(done), 32'd0);
      repeat (3) @(negedge board_clk);
      Reset = 1'b0;
      repeat (20) @(negedge board_clk);
      check("post_rst_idle_busy", 32'(busy), 32'd0);

      // Error counter saturation, cleared by a later start.
      push_clear();
      pulse_start();
      burst(COLS * ROWS, "clear4", 1'b0);
      for (int i = 0; i < 20; i++) begin
         case (i % 4)
            0: offer(5, 3, 0, 0, 1'b0, 1'b1);
            1: offer(0, 0, 4, 2, 1'b0, 1'b1);
            2: offer(40, 40, 0, 0, 1'b0, 1'b1);
            default: offer(0, 0, 30, 30, 1'b0, 1'b1);
         endcase
      end
      check("err_saturated", 32'(err_count), 32'd15);
      offer(7, 2, 0, 0, 1'b1, 1'b1);
      check("reject_last_done", 32'(done), 32'd1);
      check("reject_last_err", 32'(err_count), 32'd15);
      push_clear();
      pulse_start();
      burst(COLS * ROWS, "clear5", 1'b0);
      check("queue_drained", 32'(exp_addr.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
